// File: rtl/rtlola_verdict_collector.sv
// Captures active monitor outputs as timestamped frames into a FIFO and serializes them one beat per active stream.
// First beat appears two edges after capture; beats stall on m_ready=0; captures into a full FIFO with no pop are dropped and counted.
module rtlola_verdict_collector #(
  parameter int NUM_OUT = 12,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 8,
  parameter int TS_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_aktv,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [3:0]                m_idx,
  output logic [DATA_W-1:0]         m_data,
  output logic [TS_W-1:0]           m_ts,
  output logic                      m_last,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = NUM_OUT * DATA_W;
  localparam int FW = TS_W + NUM_OUT + PW;

  typedef enum logic {IDLE, EMIT} state_t;

  logic [FW-1:0]      mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [TS_W-1:0]    ts;
  state_t             state;
  logic [NUM_OUT-1:0] w_mask;
  logic [PW-1:0]      w_data;

  logic               empty, full, capture, pop, push, drop;
  logic [FW-1:0]      head;
  logic [TS_W-1:0]    head_ts;
  logic [NUM_OUT-1:0] head_mask;
  logic [PW-1:0]      head_data;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign capture = en && (|out_aktv);
  assign pop     = (state == IDLE) && !empty;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the capture.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_ts   = head[FW-1 -: TS_W];
  assign head_mask = head[PW +: NUM_OUT];
  assign head_data = head[PW-1:0];

  logic [NUM_OUT-1:0] rem_mask, src_mask;
  logic [PW-1:0]      src_data;
  logic [3:0]         sel_idx;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_last;

  // Next beat comes from the FIFO head when loading, else from the mask left after the current beat.
  always_comb begin
    rem_mask = w_mask & ~(NUM_OUT'(1) << m_idx);
    src_mask = (state == IDLE) ? head_mask : rem_mask;
    src_data = (state == IDLE) ? head_data : w_data;
    sel_idx  = '0;
    sel_data = '0;
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (src_mask[i]) begin
        sel_idx  = 4'(i);
        sel_data = src_data[i*DATA_W +: DATA_W];
      end
    end
    sel_last = ((src_mask & (src_mask - NUM_OUT'(1))) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ts       <= '0;
      state    <= IDLE;
      w_mask   <= '0;
      w_data   <= '0;
      m_valid  <= 1'b0;
      m_idx    <= '0;
      m_data   <= '0;
      m_ts     <= '0;
      m_last   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (en)
        ts <= ts + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (!empty) begin
            rd_ptr  <= rd_ptr + 1'b1;
            w_mask  <= head_mask;
            w_data  <= head_data;
            m_ts    <= head_ts;
            m_valid <= 1'b1;
            m_idx   <= sel_idx;
            m_data  <= sel_data;
            m_last  <= sel_last;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (m_ready) begin
            w_mask <= rem_mask;
            if (m_last) begin
              m_valid <= 1'b0;
              state   <= IDLE;
            end else begin
              m_idx  <= sel_idx;
              m_data <= sel_data;
              m_last <= sel_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {ts, out_aktv, out_data};
  end

endmodule

// File: tb/tb_rtlola_verdict_collector.sv
// Bench for rtlola_verdict_collector: directed scenarios plus random traffic checked against a frame-queue model.
module tb_rtlola_verdict_collector;

  localparam int NUM_OUT = 12;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 8;

  logic                      clk = 1'b0;
  logic                      rst, en, m_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_aktv;
  logic                      m_valid, m_last, overflow;
  logic [3:0]                m_idx;
  logic [DATA_W-1:0]         m_data;
  logic [31:0]               m_ts;
  logic [15:0]               drop_cnt;

  logic        w_en, w_ready, w_valid, w_last, w_ovf;
  logic [15:0] w_data;
  logic [1:0]  w_aktv;
  logic [3:0]  w_idx, w_ts, w_drops;
  logic [7:0]  w_mdata;

  always #5 clk = ~clk;

  rtlola_verdict_collector dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_data(m_data),
    .m_ts(m_ts), .m_last(m_last), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  rtlola_verdict_collector #(.NUM_OUT(2), .DATA_W(8), .DEPTH(2), .TS_W(4), .CNT_W(4)) u_wrap (
    .clk(clk), .rst(rst), .en(w_en), .out_data(w_data), .out_aktv(w_aktv),
    .m_valid(w_valid), .m_ready(w_ready), .m_idx(w_idx), .m_data(w_mdata),
    .m_ts(w_ts), .m_last(w_last), .overflow(w_ovf), .drop_cnt(w_drops)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of whole frames plus the frame currently being sent.
  typedef struct packed {
    logic [31:0]               ts;
    logic [NUM_OUT-1:0]        mask;
    logic [NUM_OUT*DATA_W-1:0] data;
  } frame_t;

  frame_t      q[$];
  frame_t      w;
  bit          busy;
  logic [31:0] mts;
  int          drops;
  bit          ovf;

  function automatic int low_idx(input logic [NUM_OUT-1:0] m);
    for (int i = 0; i < NUM_OUT; i++)
      if (m[i]) return i;
    return 0;
  endfunction

  task automatic mdl_edge();
    frame_t f;
    bit     was_busy;
    if (rst) begin
      q.delete();
      busy  = 0;
      mts   = 0;
      drops = 0;
      ovf   = 0;
      return;
    end
    was_busy = busy;
    if (busy && m_ready) begin
      w.mask[low_idx(w.mask)] = 1'b0;
      if (w.mask == '0) busy = 0;
    end
    if (!was_busy && q.size() > 0) begin
      w    = q.pop_front();
      busy = 1;
    end
    if (en && out_aktv != '0) begin
      if (q.size() < DEPTH) begin
        f.ts   = mts;
        f.mask = out_aktv;
        f.data = out_data;
        q.push_back(f);
      end else begin
        ovf = 1;
        if (drops < 65535) drops++;
      end
    end
    if (en) mts = mts + 1;
  endtask

  task automatic mdl_check();
    int i;
    chk("valid", m_valid, busy);
    if (busy) begin
      i = low_idx(w.mask);
      chk("idx", m_idx, i);
      chk("data", m_data, w.data[i*DATA_W +: DATA_W]);
      chk("ts", m_ts, w.ts);
      chk("last", m_last, $countones(w.mask) == 1);
    end
    chk("overflow", overflow, ovf);
    chk("drop_cnt", drop_cnt, drops);
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_edge();
    @(negedge clk);
    mdl_check();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_stream(input int s, input logic [63:0] v);
    out_data[s*DATA_W +: DATA_W] = v;
  endtask

  int rdy_bias;

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; out_aktv = '0; out_data = '0;
    w_en = 1'b0; w_ready = 1'b1; w_aktv = '0; w_data = '0;
    busy = 0; mts = 0; drops = 0; ovf = 0;
    tick();
    tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_idx", m_idx, 0);
    chk("rst_data", m_data, 0);
    chk("rst_ts", m_ts, 0);
    chk("rst_last", m_last, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_cnt, 0);
    rst = 1'b0;

    // Timestamp wrap on the narrow instance; the main instance sits with en=0.
    w_en = 1'b1;
    repeat (15) tick();
    w_aktv = 2'b01; w_data = 16'h2211;
    tick();
    w_aktv = 2'b10;
    tick();
    chk("wrap_v1", w_valid, 1);
    chk("wrap_ts1", w_ts, 15);
    chk("wrap_d1", w_mdata, 8'h11);
    chk("wrap_last1", w_last, 1);
    w_aktv = 2'b00;
    tick();
    tick();
    chk("wrap_v2", w_valid, 1);
    chk("wrap_ts2", w_ts, 0);
    chk("wrap_idx2", w_idx, 1);
    chk("wrap_d2", w_mdata, 8'h22);
    w_en = 1'b0;
    tick();
    chk("main_ts_frozen", mts, 0);

    // Single frame at ts=500.
    en = 1'b1; m_ready = 1'b1;
    repeat (500) tick();
    out_data = '0; set_stream(0, 1); set_stream(2, 3); out_aktv = 12'h005;
    tick();
    out_aktv = '0;
    tick();
    chk("sf_valid", m_valid, 1);
    chk("sf_idx0", m_idx, 0);
    chk("sf_data0", m_data, 1);
    chk("sf_ts0", m_ts, 500);
    chk("sf_last0", m_last, 0);
    tick();
    chk("sf_idx1", m_idx, 2);
    chk("sf_data1", m_data, 3);
    chk("sf_last1", m_last, 1);
    tick();
    chk("sf_gap", m_valid, 0);

    // Backpressure: payload must hold while m_ready=0.
    m_ready = 1'b0; out_aktv = 12'h005;
    tick();
    out_aktv = '0;
    tick();
    repeat (5) begin
      tick();
      chk("bp_idx", m_idx, 0);
      chk("bp_data", m_data, 1);
    end
    m_ready = 1'b1;
    tick();
    chk("bp_idx1", m_idx, 2);
    tick();
    tick();

    // Overflow: only frame 10 is lost.
    reset_pulse();
    m_ready = 1'b0; en = 1'b1; out_data = '0;
    for (int i = 1; i <= 10; i++) begin
      out_aktv = 12'h001; set_stream(0, i);
      tick();
    end
    out_aktv = '0;
    chk("ovf_cnt", drop_cnt, 1);
    chk("ovf_flag", overflow, 1);
    m_ready = 1'b1;
    repeat (25) tick();

    // Full FIFO with an idle emitter popping on the capture edge.
    reset_pulse();
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      out_aktv = 12'h001; set_stream(0, i);
      tick();
    end
    out_aktv = '0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0; out_aktv = 12'h001; set_stream(0, 100);
    tick();
    chk("fp_no_drop", drop_cnt, 0);
    set_stream(0, 101);
    tick();
    chk("fp_drop", drop_cnt, 1);
    out_aktv = '0; m_ready = 1'b1;
    repeat (25) tick();

    // Reset in the middle of a 3-beat frame, then ts restarts from 0.
    set_stream(0, 64'hA); set_stream(1, 64'hB); set_stream(2, 64'hC);
    out_aktv = 12'h007;
    tick();
    out_aktv = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", m_valid, 0);
    rst = 1'b0;
    repeat (4) tick();
    out_aktv = 12'h001; set_stream(0, 64'h77);
    tick();
    out_aktv = '0;
    tick();
    chk("post_rst_ts", m_ts, 4);
    chk("post_rst_data", m_data, 64'h77);
    en = 1'b0; out_aktv = 12'hFFF;
    repeat (5) tick();
    chk("en0_idle", m_valid, 0);
    en = 1'b1; out_aktv = 12'h001;
    tick();
    out_aktv = '0;
    tick();
    chk("en0_ts", m_ts, 6);
    repeat (3) tick();

    // Random traffic.
    rdy_bias = 7;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) rdy_bias = $urandom_range(1, 10);
      rst      = ($urandom_range(0, 599) == 0);
      en       = ($urandom_range(0, 9) < 8);
      m_ready  = ($urandom_range(0, 9) < rdy_bias);
      out_aktv = ($urandom_range(0, 3) == 0) ? '0 : NUM_OUT'($urandom());
      for (int j = 0; j < NUM_OUT * DATA_W / 32; j++)
        out_data[j*32 +: 32] = $urandom();
      tick();
    end
    rst = 1'b0; en = 1'b0; m_ready = 1'b1; out_aktv = '0;
    repeat (200) tick();
    chk("drained", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rtlola_verdict_collector.md
# rtlola_verdict_collector

Downstream stage of the generated RTLola monitor (`topEntity`). Each cycle, it samples every monitor output stream together with its `_aktv` flag. Any cycle with at least one active output becomes a timestamped verdict frame, which is buffered in a frame FIFO. Frames are then serialized over a valid/ready stream, one beat per active output, lowest stream index first, for a host logger or trace port.

## Interface
- `NUM_OUT`, 12, number of monitor output streams (1..16)
- `DATA_W`, 64, width of each signed output value
- `DEPTH`, 8, frame FIFO depth in frames (power of two, ≥2)
- `TS_W`, 32, timestamp width
- `CNT_W`, 16, width of the drop counter

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  same enable the monitor receives; gates capture and timestamp
- `out_data`  in  NUM_OUT*DATA_W  monitor outputs, flattened; stream i is in bits [i*DATA_W +: DATA_W]
- `out_aktv`  in  NUM_OUT  per-stream active flags
- `m_valid`  out  1  beat valid
- `m_ready`  in  1  consumer ready
- `m_idx`  out  4  stream index of the beat
- `m_data`  out  DATA_W  stream value
- `m_ts`  out  TS_W  timestamp of the frame
- `m_last`  out  1  last beat of the frame
- `overflow`  out  1  sticky; set when any frame has been dropped
- `drop_cnt`  out  CNT_W  count of dropped frames, saturating

## Operation
- Timestamp `ts`:
  - 0 after reset.
  - Increments by 1 on every edge with `en`=1.
  - Wraps modulo 2^TS_W.
  - A frame captured at an edge carries the pre-increment value.
- Capture:
  - A frame is captured on any edge with `en`=1, `rst`=0 and `|out_aktv`=1.
  - The frame is written to the FIFO as {ts, out_aktv, out_data}.
  - Inactive streams' data need not be stored; if stored, it is never emitted.
- Drop rules:
  - A frame is dropped if the FIFO is full at the edge and no pop occurs on that same edge.
  - Full with a simultaneous pop: the frame is accepted and the count is unchanged.
  - On a drop, `drop_cnt` increments, saturating at all-ones, and `overflow` is set.
- `en`=0 freezes capture and `ts` only. The emitter keeps draining.
- Emitter FSM:
  - IDLE: if the FIFO is non-empty, pop the head into the working register (`ts`, remaining mask, data) and go to EMIT.
  - EMIT:
    - `m_valid`=1.
    - `m_idx` = lowest set bit of the remaining mask, and `m_data` = that stream's value.
    - `m_ts` = frame ts.
    - `m_last` = 1 when exactly one mask bit remains.
  - On an EMIT handshake, clear that mask bit. If `m_last`=1, return to IDLE.
- Every frame contains ≥1 set bit, so EMIT is never entered with an empty mask.
- Payload stability: while `m_valid`=1 and `m_ready`=0, `m_idx`, `m_data`, `m_ts` and `m_last` hold. `m_valid` never drops without a handshake except on reset.
- Frames are emitted in capture order. Beats within a frame are in ascending index order.

## Timing
- Reset values:
  - `m_valid`=0, `m_idx`=0, `m_data`=0, `m_ts`=0, `m_last`=0.
  - `overflow`=0, `drop_cnt`=0.
  - FIFO empty, FSM in IDLE, `ts`=0.
- Reset mid-frame discards the working frame and all FIFO contents. `m_valid` is 0 in the cycle after the reset edge.
- Latency:
  - A frame captured at edge k is popped at edge k+1 if the emitter is idle.
  - `m_valid` rises in the cycle after edge k+1.
- Beat rate:
  - One beat per cycle inside a frame while `m_ready`=1.
  - One idle cycle between frames, for the IDLE pop.
- Sustained throughput ≥ 1 frame per (active outputs + 1) cycles. Faster capture rates fill the FIFO.
- `drop_cnt` and `overflow` update on the same edge as the rejected capture.

## Test plan
- Single frame:
  - Stimulus: at ts=500, `out_aktv`=0x005, stream0=1, stream2=3, `m_ready`=1.
  - Response:
    - Beat (idx0, data1, ts500, last0) in the cycle after edge k+1.
    - Then beat (idx2, data3, ts500, last1) in the next cycle.
- Backpressure:
  - Stimulus: same frame with `m_ready`=0 for 5 cycles after `m_valid` rises.
  - Response: payload constant for all 5 cycles; handshakes follow exactly as in the single-frame case.
- Overflow:
  - Stimulus: DEPTH=8, `m_ready`=0, 10 consecutive active cycles with `out_aktv`=0x001 and data 1..10.
  - Response:
    - 8 frames kept; `drop_cnt`=1 and `overflow`=1.
    - The working register takes frame 1, so only frame 10 is dropped.
    - Draining yields data 1..9 with ascending ts.
- Full plus simultaneous pop:
  - Stimulus: FIFO full and idle emitter popping on the same edge as a capture.
  - Response: frame accepted, `drop_cnt` unchanged.
- Reset and enable:
  - Stimulus: `rst` mid-EMIT of a 3-beat frame.
  - Response: `m_valid`=0 the next cycle and no residual beats.
  - Stimulus: next capture after reset at edge 4.
  - Response: that frame carries ts=4.
  - Stimulus: `en`=0 with `out_aktv`=0xFFF.
  - Response: no frame captured, `ts` frozen.
- Wrap-around:
  - Stimulus: TS_W=4, capture at ts=15 and the next `en` cycle.
  - Response: frames carry ts 15 and 0.
